dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Multi-cycle data-memory controller directly downstream of the MEM stage.
- Accepts the MEM stage's read/write request (re, we, addr, wrt_data), models a word-addressed data RAM with configurable access latency, and returns rd_data.
- Drives a stall back to the pipeline so the MEM stage holds its request until the access completes.
- Replaces the single-cycle data memory in the 16-bit pipeline.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width (word address).
- DEPTH, 1024, number of RAM words; index = addr mod DEPTH.
- RD_LAT, 2, read latency in cycles (>=1).
- WR_LAT, 1, write latency in cycles (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- re  in  1  read request from MEM stage (mem_to_reg).
- we  in  1  write request from MEM stage (reg_to_mem).
- addr  in  ADDR_W  word address (ALU result).
- wrt_data  in  DATA_W  write data.
- rd_data  out  DATA_W  read data; holds until the next read completes.
- rd_valid  out  1  one-cycle pulse: rd_data updated this cycle.
- stall  out  1  combinational; pipeline must hold the MEM stage while high.
- err  out  1  sticky flag: re and we were both high at request accept.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rd_data=0, rd_valid=0, err=0, counter=0.
  - stall evaluates to 0 once re/we are low.
  - RAM contents are not cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If re|we at the rising edge, latch op/addr/data.
  - Load counter = LAT-1 (LAT = RD_LAT for a read, WR_LAT for a write).
  - Go to BUSY if LAT>1, else straight to DONE.
- BUSY: counter decrements each cycle; at 0, go to DONE.
- Entry to DONE:
  - Write: RAM[addr mod DEPTH] <= data.
  - Read: rd_data <= RAM[index].
- DONE: rd_valid=1 for a read (0 for a write), then IDLE on the next edge. A request still asserted in DONE is the completed one and is not relaunched.
- stall = (IDLE & (re|we)) | BUSY.
- Timing: request presented in cycle 0 → stall high for cycles 0..LAT-1, low in cycle LAT. The read result (rd_valid=1) is visible in cycle LAT, and the MEM stage advances at the end of cycle LAT.
- Back-to-back: a new request is presented in cycle LAT+1 (IDLE) and is accepted normally; throughput is one access per LAT+1 cycles.
- re & we both high at accept: performed as a write only, err<=1 (sticky until reset).
- Addresses ≥ DEPTH wrap (upper bits ignored).
- Reset mid-access:
  - Abort to IDLE.
  - A write whose DONE-entry edge has not occurred is dropped (RAM unchanged).
  - rd_valid=0 and rd_data=0 immediately.
- Inputs re/we/addr/wrt_data are sampled only at accept; changes during BUSY are ignored.

Optional Feature:
- Macro: DMEM_CTRL_WRITE_BUFFER_EN.
- Defined: single-entry posted write buffer.
  - A write in IDLE with the buffer empty is captured into the buffer with stall=0 (zero-stall write).
  - The buffer drains to RAM through the BUSY/DONE path with WR_LAT, without asserting stall.
  - A write while the buffer is occupied or draining stalls until the drain completes, then is captured.
  - A read while the buffer is occupied:
    - address match → data forwarded from the buffer, read still takes RD_LAT cycles;
    - no match → read waits (stall high) until the drain completes, then executes.
  - err behaviour is unchanged.
- Undefined: no buffer; every write stalls for WR_LAT cycles as described above.

Test Plan:
- Reset then a read of addr 0x0005 (RAM preloaded 0xBEEF), RD_LAT=2 → stall high in cycles 0–1, rd_valid=1 and rd_data=0xBEEF in cycle 2.
- Write 0x1234 to 0x0010 (WR_LAT=1), then read 0x0010 → write stall for 1 cycle; read returns 0x1234 two cycles after it is presented.
- re=we=1, addr 0x0003, data 0xAAAA → err=1 and stays 1; a later read of 0x0003 returns 0xAAAA.
- Write 0x5555 to addr 0x0402 with DEPTH=1024, then read 0x0002 → 0x5555 (wrap).
- rst_n pulsed low in cycle 1 of a RD_LAT=3 read → rd_valid never pulses, rd_data=0, state IDLE, no stall after release.
- With DMEM_CTRL_WRITE_BUFFER_EN: write 0x0F0F to 0x0020 then an immediate read of 0x0020 → write stall=0; read returns 0x0F0F via forwarding after RD_LAT cycles.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data RAM behind the MEM stage, with stall back to the pipe.
// Define DMEM_CTRL_WRITE_BUFFER_EN for a single-entry posted write buffer.
module dmem_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              re,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wrt_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              stall,
   output logic              err
);

   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_we_q, op_we_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [IDX_W-1:0]  in_idx, acc_idx;
   logic [DATA_W-1:0] acc_data, rd_src;
   logic              acc, acc_we, done_go, mem_we, stall_c;

`ifdef DMEM_CTRL_WRITE_BUFFER_EN
   logic              buf_v_q, buf_v_d;
   logic [IDX_W-1:0]  buf_idx_q, buf_idx_d;
   logic [DATA_W-1:0] buf_data_q, buf_data_d;
   logic              buf_hit;
`endif

   // upper address bits beyond DEPTH are ignored
   assign in_idx = IDX_W'(32'(addr) % 32'(DEPTH));

   // next-state, accept/complete decisions and stall
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_we_d   = op_we_q;
      idx_d     = idx_q;
      data_d    = data_q;
      rd_data_d = rd_data_q;
      err_d     = err_q;
      acc       = 1'b0;
      acc_we    = we;
      acc_idx   = in_idx;
      acc_data  = wrt_data;
      done_go   = 1'b0;
      stall_c   = 1'b0;
`ifdef DMEM_CTRL_WRITE_BUFFER_EN
      buf_v_d    = buf_v_q;
      buf_idx_d  = buf_idx_q;
      buf_data_d = buf_data_q;
      buf_hit    = buf_v_q && (buf_idx_q == in_idx);
`endif
      unique case (state_q)
         IDLE: begin
`ifdef DMEM_CTRL_WRITE_BUFFER_EN
            // reads bypass a pending write only when they hit it
            if (re && !we && (!buf_v_q || buf_hit)) begin
               acc     = 1'b1;
               acc_we  = 1'b0;
               stall_c = 1'b1;
            end else if (buf_v_q) begin
               acc      = 1'b1;
               acc_we   = 1'b1;
               acc_idx  = buf_idx_q;
               acc_data = buf_data_q;
               stall_c  = re | we;
            end else if (we) begin
               buf_v_d    = 1'b1;
               buf_idx_d  = in_idx;
               buf_data_d = wrt_data;
               err_d      = err_q | re;
            end
`else
            acc     = re | we;
            acc_we  = we;
            stall_c = re | we;
            if (re && we) err_d = 1'b1;
`endif
            if (acc) begin
               op_we_d = acc_we;
               idx_d   = acc_idx;
               data_d  = acc_data;
               if ((acc_we ? WR_LAT : RD_LAT) > 1) begin
                  state_d = BUSY;
                  cnt_d   = acc_we ? WR_LOAD : RD_LOAD;
               end else begin
                  state_d = DONE;
                  done_go = 1'b1;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
`ifdef DMEM_CTRL_WRITE_BUFFER_EN
            stall_c = op_we_q ? (re | we) : 1'b1;
`else
            stall_c = 1'b1;
`endif
            if (cnt_q <= CNT_W'(1)) begin
               state_d = DONE;
               done_go = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef DMEM_CTRL_WRITE_BUFFER_EN
            stall_c = op_we_q & (re | we);
`endif
         end
         default: state_d = IDLE;
      endcase

      mem_we = done_go && op_we_d;
      rd_src = mem_q[idx_d];
`ifdef DMEM_CTRL_WRITE_BUFFER_EN
      if (buf_v_q && (buf_idx_q == idx_d)) rd_src = buf_data_q;
      if (mem_we) buf_v_d = 1'b0;
`endif
      if (done_go && !op_we_d) rd_data_d = rd_src;
   end

   // control and result registers, cleared on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_we_q   <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_we_q   <= op_we_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
      end
   end

`ifdef DMEM_CTRL_WRITE_BUFFER_EN
   // posted write entry; a reset drops it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_v_q    <= 1'b0;
         buf_idx_q  <= '0;
         buf_data_q <= '0;
      end else begin
         buf_v_q    <= buf_v_d;
         buf_idx_q  <= buf_idx_d;
         buf_data_q <= buf_data_d;
      end
   end
`endif

   // RAM array keeps contents across reset; writes blocked while in reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
      end else if (mem_we) begin
         mem_q[idx_d] <= data_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = (state_q == DONE) && !op_we_q;
   assign stall    = stall_c;
   assign err      = err_q;

endmodule
